stepgen_multi: RTL and testbench

STEPGEN_MULTI -- requirements
Module: stepgen_multi

---
 rtl/stepgen_multi.sv | 96 +++++++++
 tb/tb_stepgen_multi.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepgen_multi.sv
// stepgen_multi: per-channel step/dir pulse generator with ramped velocity and
// fractional position accumulators; a step fires whenever accumulator bit F toggles.
module stepgen_multi #(
  parameter int CH = 4,
  parameter int W  = 12,
  parameter int F  = 10,
  parameter int T  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH-1:0]        enable,
  input  logic [CH*(F+1)-1:0]  vel_tgt,
  input  logic [F-1:0]         accel,
  input  logic                 ramp_tick,
  input  logic [T-1:0]         steptime,
  input  logic [T-1:0]         dirtime,
  output logic [CH*(W+F)-1:0]  pos,
  output logic [CH-1:0]        step,
  output logic [CH-1:0]        dir
);
  localparam int A = W + F;
  typedef enum logic [1:0] {READY, DIRSETUP, STEPHI, STEPLO} state_t;
  logic [T-1:0] w_st, w_dt;
  // timers count down to zero, so reload with max(x,1)-1
  assign w_st = (steptime == '0) ? '0 : steptime - T'(1);
  assign w_dt = (dirtime == '0) ? '0 : dirtime - T'(1);
  for (genvar n = 0; n < CH; n++) begin : g_ch
    state_t r_state, w_state;
    logic signed [F:0] w_raw, w_tgt, r_vel, w_vel;
    logic signed [F+1:0] w_diff;
    logic [F+1:0] w_mag;
    logic [A-1:0] r_acc, w_acc, w_sum;
    logic [T-1:0] r_tmr, w_tmr;
    logic r_step, w_step, r_dir, w_dir, w_run, w_req, w_done, w_chg;
    assign w_raw = vel_tgt[n*(F+1) +: F+1];
    assign w_tgt = (w_raw == {1'b1, {F{1'b0}}}) ? {1'b1, {(F-1){1'b0}}, 1'b1} : w_raw;
    assign w_diff = {w_tgt[F], w_tgt} - {r_vel[F], r_vel};
    assign w_mag = w_diff[F+1] ? -w_diff : w_diff;
    assign w_vel = (accel == '0) ? w_tgt
                 : !ramp_tick ? r_vel
                 : (w_mag <= {2'b00, accel}) ? w_tgt
                 : w_diff[F+1] ? r_vel - {1'b0, accel} : r_vel + {1'b0, accel};
    assign w_run = (r_state == READY) && enable[n];
    assign w_sum = r_acc + {{(A-F-1){w_vel[F]}}, w_vel};
    assign w_req = w_run && (w_sum[F] != r_acc[F]);
    assign w_done = (r_tmr == '0);
    // required direction is ~sign, so a change is needed when sign equals dir
    assign w_chg = (w_vel[F] == r_dir);
    always_comb begin
      w_state = r_state;
      w_tmr = w_done ? r_tmr : r_tmr - T'(1);
      w_step = r_step;
      w_dir = r_dir;
      w_acc = w_run ? w_sum : r_acc;
      case (r_state)
        READY: if (w_req) begin
          w_dir = ~w_vel[F];
          w_state = w_chg ? DIRSETUP : STEPHI;
          w_tmr = w_chg ? w_dt : w_st;
          w_step = ~w_chg;
        end
        DIRSETUP: if (w_done) begin
          w_state = STEPHI;
          w_tmr = w_st;
          w_step = 1'b1;
        end
        STEPHI: if (w_done) begin
          w_state = STEPLO;
          w_tmr = w_st;
          w_step = 1'b0;
        end
        default: if (w_done) w_state = READY;
      endcase
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= READY;
        r_vel <= '0;
        r_acc <= '0;
        r_tmr <= '0;
        r_step <= 1'b0;
        r_dir <= 1'b0;
      end else begin
        r_state <= w_state;
        r_vel <= w_vel;
        r_acc <= w_acc;
        r_tmr <= w_tmr;
        r_step <= w_step;
        r_dir <= w_dir;
      end
    end
    assign pos[n*A +: A] = r_acc;
    assign step[n] = r_step;
    assign dir[n] = r_dir;
  end
endmodule

// File: tb/tb_stepgen_multi.sv
// tb_stepgen_multi: directed and randomized checks of stepgen_multi against a
// behavioural model built from velocity, accumulator and pulse-schedule rules.
module tb_stepgen_multi;
  localparam int CH = 4, W = 12, F = 10, T = 5, A = W + F, V = F + 1;
  logic clk = 1'b0, reset = 1'b0;
  logic [CH-1:0] enable = '0;
  logic [CH*V-1:0] vel_tgt = '0;
  logic [F-1:0] accel = '0;
  logic ramp_tick = 1'b0;
  logic [T-1:0] steptime = T'(2), dirtime = T'(3);
  logic [CH*A-1:0] pos;
  logic [CH-1:0] step, dir;
  int n_tests = 0, n_fail = 0;
  int m_vel[CH];
  logic [A-1:0] m_acc[CH];
  logic [CH-1:0] m_step, m_dir;
  int m_rem[CH];
  int m_seg[CH][$];

  stepgen_multi #(.CH(CH), .W(W), .F(F), .T(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vel_tgt(vel_tgt), .accel(accel),
    .ramp_tick(ramp_tick), .steptime(steptime), .dirtime(dirtime),
    .pos(pos), .step(step), .dir(dir));

  always #5 clk = ~clk;

  function automatic int len(input logic [T-1:0] x);
    return (x == 0) ? 1 : int'(x);
  endfunction

  function automatic int tgt_of(input int c);
    int t;
    t = $signed(vel_tgt[c*V +: V]);
    return (t == -(1 << F)) ? -((1 << F) - 1) : t;
  endfunction

  function automatic logic [CH*A-1:0] m_posv();
    logic [CH*A-1:0] v;
    for (int c = 0; c < CH; c++) v[c*A +: A] = m_acc[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_vel[c] = 0;
      m_acc[c] = '0;
      m_rem[c] = 0;
      m_seg[c].delete();
    end
    m_step = '0;
    m_dir = '0;
  endtask

  // m_rem counts cycles left in the current busy segment; m_seg lists the
  // segments still to come (1 = step high, 2 = step low)
  task automatic model_edge();
    int t, d, a, nv, k;
    logic [A-1:0] na;
    if (reset) return;
    a = int'(accel);
    for (int c = 0; c < CH; c++) begin
      t = tgt_of(c);
      d = t - m_vel[c];
      nv = (a == 0) ? t : !ramp_tick ? m_vel[c] : (d <= a && d >= -a) ? t : (d > 0) ? m_vel[c] + a : m_vel[c] - a;
      if (m_rem[c] > 0) begin
        m_rem[c]--;
        if (m_rem[c] == 0 && m_seg[c].size() > 0) begin
          k = m_seg[c].pop_front();
          m_step[c] = (k == 1);
          m_rem[c] = len(steptime);
        end
      end else if (enable[c]) begin
        na = m_acc[c] + A'(nv);
        if (na[F] != m_acc[c][F]) begin
          m_seg[c].delete();
          if ((nv >= 0) != m_dir[c]) begin
            m_dir[c] = (nv >= 0);
            m_rem[c] = len(dirtime);
            m_seg[c].push_back(1);
          end else begin
            m_step[c] = 1'b1;
            m_rem[c] = len(steptime);
          end
          m_seg[c].push_back(2);
        end
        m_acc[c] = na;
      end
      m_vel[c] = nv;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (step !== '0) begin n_fail++; $display("FAIL reset_step got %b want 0", step); end
    n_tests++; if (dir !== '0) begin n_fail++; $display("FAIL reset_dir got %b want 0", dir); end
    n_tests++; if (pos !== '0) begin n_fail++; $display("FAIL reset_pos got %h want 0", pos); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic es, ed;
    do_reset();
    enable = CH'(1); vel_tgt = '0; vel_tgt[0 +: V] = V'(256);
    accel = '0; ramp_tick = 1'b0; steptime = T'(2); dirtime = T'(3);
    for (int c = 1; c <= 40; c++) begin
      cyc();
      es = (c >= 7) && ((c - 7) % 8 < 2);
      ed = (c >= 4);
      n_tests++; if (step[0] !== es) begin n_fail++; $display("FAIL basic_step cyc=%0d got %b want %b", c, step[0], es); end
      n_tests++; if (dir[0] !== ed) begin n_fail++; $display("FAIL basic_dir cyc=%0d got %b want %b", c, dir[0], ed); end
      n_tests++; if (pos !== m_posv()) begin n_fail++; $display("FAIL basic_pos cyc=%0d got %h want %h", c, pos, m_posv()); end
    end
  endtask

  task automatic test_reverse();
    int rises, dfall;
    logic ps, pd;
    logic [A-1:0] pp;
    do_reset();
    enable = CH'(2); vel_tgt = '0; vel_tgt[V +: V] = V'(256);
    accel = '0; steptime = T'(2); dirtime = T'(3);
    rises = 0;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      ps = step[1];
      cyc();
      if (step[1] && !ps) rises++;
      n_tests++; if (pos !== m_posv() || step !== m_step || dir !== m_dir) begin n_fail++; $display("FAIL reverse_fwd i=%0d got %h/%b/%b want %h/%b/%b", i, pos, step, dir, m_posv(), m_step, m_dir); end
    end
    n_tests++; if (rises != 5) begin n_fail++; $display("FAIL reverse_5steps got %0d want 5", rises); end
    vel_tgt[V +: V] = V'(-512);
    dfall = -1;
    for (int i = 0; i < 60; i++) begin
      pp = pos[A +: A]; ps = step[1]; pd = dir[1];
      cyc();
      n_tests++; if (pos !== m_posv() || step !== m_step || dir !== m_dir) begin n_fail++; $display("FAIL reverse_model i=%0d got %h/%b/%b want %h/%b/%b", i, pos, step, dir, m_posv(), m_step, m_dir); end
      if (dfall < 0 && pd && !dir[1]) begin
        dfall = i;
        n_tests++; if (step[1] !== 1'b0) begin n_fail++; $display("FAIL reverse_setup_step got %b want 0", step[1]); end
      end
      if (dfall >= 0 && i == dfall + 3) begin
        n_tests++; if (step[1] !== 1'b1 || ps !== 1'b0) begin n_fail++; $display("FAIL reverse_step_delay got %b%b want 01", ps, step[1]); end
      end
      if (pos[A +: A] != pp) begin
        n_tests++; if (pp - pos[A +: A] !== A'(512)) begin n_fail++; $display("FAIL reverse_delta got %0d want 512", pp - pos[A +: A]); end
      end
    end
    n_tests++; if (dfall < 0) begin n_fail++; $display("FAIL reverse_dir_drop got no drop want drop within 60 cycles"); end
  endtask

  task automatic test_ramp();
    do_reset();
    enable = '0; vel_tgt = '0; vel_tgt[2*V +: V] = V'(256);
    accel = F'(16); ramp_tick = 1'b1; steptime = T'(2); dirtime = T'(3);
    repeat (15) cyc();
    ramp_tick = 1'b0; enable = CH'(4);
    cyc();
    n_tests++; if (pos[2*A +: A] !== A'(240)) begin n_fail++; $display("FAIL ramp_15ticks got %0d want 240", pos[2*A +: A]); end
    enable = '0; ramp_tick = 1'b1;
    cyc();
    enable = CH'(4);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_tests++; if (pos[2*A +: A] !== A'(240 + 256 * i)) begin n_fail++; $display("FAIL ramp_hold i=%0d got %0d want %0d", i, pos[2*A +: A], 240 + 256 * i); end
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_tests++; if (pos !== m_posv() || step !== m_step || dir !== m_dir) begin n_fail++; $display("FAIL ramp_model i=%0d got %h/%b/%b want %h/%b/%b", i, pos, step, dir, m_posv(), m_step, m_dir); end
    end
    ramp_tick = 1'b0;
  endtask

  task automatic test_enable_drop();
    int r;
    logic [A-1:0] pp;
    do_reset();
    enable = CH'(8); vel_tgt = '0; vel_tgt[3*V +: V] = V'(256);
    accel = '0; steptime = T'(2); dirtime = T'(1);
    r = -1;
    for (int i = 0; i < 40 && r < 0; i++) begin
      cyc();
      if (step[3]) r = i;
    end
    n_tests++; if (r < 0) begin n_fail++; $display("FAIL drop_wait got no step want step within 40 cycles"); end
    enable = '0;
    pp = pos[3*A +: A];
    for (int i = 1; i <= 10; i++) begin
      cyc();
      n_tests++; if (step[3] !== (i == 1)) begin n_fail++; $display("FAIL drop_step i=%0d got %b want %b", i, step[3], i == 1); end
      n_tests++; if (pos[3*A +: A] !== pp) begin n_fail++; $display("FAIL drop_pos i=%0d got %0d want %0d", i, pos[3*A +: A], pp); end
    end
    enable = CH'(8);
    cyc();
    n_tests++; if (pos[3*A +: A] !== pp + A'(256)) begin n_fail++; $display("FAIL drop_resume got %0d want %0d", pos[3*A +: A], pp + A'(256)); end
  endtask

  task automatic test_wrap();
    int rises, w;
    logic ps;
    do_reset();
    enable = CH'(1); vel_tgt = '0; vel_tgt[0 +: V] = V'(-1000);
    accel = '0; steptime = T'(1); dirtime = T'(1);
    cyc();
    n_tests++; if (pos[0 +: A] !== A'((1 << A) - 1000)) begin n_fail++; $display("FAIL wrap_preload got %0d want %0d", pos[0 +: A], (1 << A) - 1000); end
    vel_tgt[0 +: V] = V'(1023);
    rises = 0; w = -1;
    for (int i = 0; i < 15; i++) begin
      ps = step[0];
      cyc();
      if (step[0] && !ps) rises++;
      if (w < 0 && pos[0 +: A] < A'(1024)) begin
        w = i;
        enable = '0;
        n_tests++; if (pos[0 +: A] !== A'(23)) begin n_fail++; $display("FAIL wrap_value got %0d want 23", pos[0 +: A]); end
      end
    end
    n_tests++; if (w < 0) begin n_fail++; $display("FAIL wrap_seen got no wrap want wrap within 15 cycles"); end
    n_tests++; if (rises != 1) begin n_fail++; $display("FAIL wrap_steps got %0d want 1", rises); end
  endtask

  task automatic test_clamp();
    do_reset();
    enable = CH'(4); vel_tgt = '0; vel_tgt[2*V +: V] = V'(-1024);
    accel = '0; steptime = T'(2); dirtime = T'(3);
    cyc();
    n_tests++; if (pos[2*A +: A] !== A'((1 << A) - 1023)) begin n_fail++; $display("FAIL clamp_pos got %0d want %0d", pos[2*A +: A], (1 << A) - 1023); end
    n_tests++; if (step[2] !== 1'b1 || dir[2] !== 1'b0) begin n_fail++; $display("FAIL clamp_step got step=%b dir=%b want step=1 dir=0", step[2], dir[2]); end
  endtask

  task automatic test_timing_sample();
    logic es;
    do_reset();
    enable = CH'(1); vel_tgt = '0; vel_tgt[0 +: V] = V'(256);
    accel = '0; steptime = T'(3); dirtime = T'(2);
    for (int i = 0; i < 30 && !dir[0]; i++) cyc();
    n_tests++; if (dir[0] !== 1'b1) begin n_fail++; $display("FAIL sample_dir got %b want 1", dir[0]); end
    dirtime = T'(7);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (i == 2) steptime = T'(1);
      es = (i >= 2 && i <= 4);
      n_tests++; if (step[0] !== es) begin n_fail++; $display("FAIL sample_step i=%0d got %b want %b", i, step[0], es); end
      n_tests++; if (pos !== m_posv()) begin n_fail++; $display("FAIL sample_pos i=%0d got %h want %h", i, pos, m_posv()); end
    end
    n_tests++; if (pos[0 +: A] !== A'(1280)) begin n_fail++; $display("FAIL sample_resume got %0d want 1280", pos[0 +: A]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = CH'(1); vel_tgt = '0; vel_tgt[0 +: V] = V'(256);
    accel = '0; steptime = T'(3); dirtime = T'(1);
    for (int i = 0; i < 30 && !step[0]; i++) cyc();
    n_tests++; if (step[0] !== 1'b1) begin n_fail++; $display("FAIL async_pulse got %b want 1", step[0]); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (step !== '0 || dir !== '0 || pos !== '0) begin n_fail++; $display("FAIL async_clear got %b/%b/%h want 0/0/0", step, dir, pos); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    n_tests++; if (pos[0 +: A] !== A'(256) || step[0] !== 1'b0) begin n_fail++; $display("FAIL async_first got pos=%0d step=%b want pos=256 step=0", pos[0 +: A], step[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        enable = CH'($urandom);
        for (int c = 0; c < CH; c++) vel_tgt[c*V +: V] = V'($urandom_range(0, 2047));
        accel = ($urandom_range(0, 3) == 0) ? '0 : F'($urandom_range(1, 200));
        steptime = T'($urandom_range(0, 3));
        dirtime = T'($urandom_range(0, 3));
      end
      ramp_tick = 1'($urandom_range(0, 1));
      cyc();
      n_tests++; if (pos !== m_posv() || step !== m_step || dir !== m_dir) begin n_fail++; $display("FAIL random i=%0d got %h/%b/%b want %h/%b/%b", i, pos, step, dir, m_posv(), m_step, m_dir); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_ramp();
    test_enable_drop();
    test_wrap();
    test_clamp();
    test_timing_sample();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
